pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// Stall/flush scheduler for the 5-stage MIPS pipeline. Sequences instruction fetch over a
// req/addr_ok/data_ok bus, buffers a fetched word while decode is held, and drives IF_stall/ID_stall
// to the IF/ID register plus hold/bubble controls for ID/EX and EX/MEM. Resolves load-use hazards,
// multi-cycle divide occupancy and EX-stage redirects (branch/exception) with a fixed priority.
// PARAMETERS
// DIV_CYCLES   32   cycles EX is occupied by a DIV/DIVU, including the start cycle (2..63)
// PORTS
// clk            in   1   clock, all state on rising edge
// resetn         in   1   asynchronous active-low reset
// inst_req       out  1   fetch request valid
// inst_addr_ok   in   1   fetch address accepted this cycle
// inst_data_ok   in   1   fetch data returned this cycle
// inst_rdata     in   32  fetched instruction
// fetch_inst     out  32  instruction presented to IF/ID (IF_out_instruction)
// pc_we          out  1   PC register update enable
// pc_redirect    out  1   PC loads redirect target (else PC+4)
// IF_stall       out  1   no valid fetch this cycle: IF/ID loads bubble
// ID_stall       out  1   hold IF/ID
// EX_stall       out  1   hold ID/EX
// ID_EX_bubble   out  1   ID/EX loads nop
// EX_MEM_bubble  out  1   EX/MEM loads nop
// id_rs, id_rt   in   5   source registers of instruction in ID
// ex_load        in   1   instruction in EX is a load
// ex_rd          in   5   destination register of instruction in EX
// ex_div_start   in   1   DIV/DIVU entered EX this cycle
// redirect_valid in   1   EX branch taken or exception: flush younger stages
// BEHAVIOUR
// - Reset (async, resetn=0): fetch FSM=F_IDLE, div_cnt=0, buffer=0, fetch_inst=0, inst_req=0,
//   pc_we=0, pc_redirect=0, IF_stall=1, ID_stall=0, EX_stall=0, both bubbles=0.
// - Fetch FSM: F_IDLE -> F_REQ (unconditional, one cycle after reset release).
//   F_REQ: inst_req=1; addr_ok -> F_WAIT (or F_CANCEL if redirect_valid same cycle).
//   F_WAIT: data_ok & !redirect -> delivered; if held -> F_HOLD (latch inst_rdata) else F_REQ.
//     redirect & !data_ok -> F_CANCEL; redirect & data_ok -> drop word, F_REQ.
//   F_HOLD: buffer presented each cycle; leave to F_REQ when not held; redirect -> F_REQ.
//   F_CANCEL: inst_req=0; next data_ok discarded -> F_REQ. Never more than one outstanding fetch.
// - delivered = (F_WAIT & data_ok) | F_HOLD; fetch_inst = F_HOLD ? buffer : inst_rdata; 0 otherwise.
// - held = ID_stall | EX_stall.
// - div_cnt: ex_div_start with div_cnt=0 loads DIV_CYCLES-1; decrements to 0; start while busy ignored.
//   div_busy = ex_div_start | (div_cnt!=0).
// - load_use = ex_load & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
// - Priority (highest first), combinational same cycle:
//   1 redirect_valid: IF_stall=1, ID_stall=0, EX_stall=0, ID_EX_bubble=1, pc_we=1, pc_redirect=1.
//   2 div_busy: EX_stall=1, ID_stall=1, EX_MEM_bubble=1, pc_we=0.
//   3 load_use: ID_stall=1, ID_EX_bubble=1, pc_we=0.
//   4 !delivered: IF_stall=1, pc_we=0.
//   5 else: all stalls/bubbles 0, pc_we=1, pc_redirect=0.
// - Redirect during div_busy: counter keeps counting (divider is not squashed), EX_stall drops.
// - Only the last cycle of div (div_cnt==1 -> 0) releases stalls the following cycle.
// - IF_stall is also 1 while ID_stall is set but ignored by IF/ID (ID_stall wins there).
// TESTING
// - Reset mid-fetch (F_WAIT, drop resetn): all outputs at reset values next edge; F_REQ after release.
// - addr_ok cyc1, data_ok cyc3, inst=0x24020005, no hazards -> IF_stall=1 cyc1-2, 0 and pc_we=1 cyc3.
// - ex_load=1, ex_rd=5, id_rt=5 -> ID_stall=1, ID_EX_bubble=1, pc_we=0 one cycle; ex_rd=0 -> no stall.
// - ex_div_start with DIV_CYCLES=4 -> EX_stall=ID_stall=1 for exactly 4 cycles, released cycle 5.
// - data_ok while load_use -> F_HOLD, fetch_inst=buffer word stable until stall clears, then F_REQ.
// - redirect_valid in F_WAIT -> F_CANCEL, next data_ok word never presented, pc_redirect=1 one cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: fetch bus sequencing, fetched-word buffering,
// and prioritised redirect / divide / load-use stall and bubble generation.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] fetch_inst,
  output logic        pc_we,
  output logic        pc_redirect,
  output logic        IF_stall,
  output logic        ID_stall,
  output logic        EX_stall,
  output logic        ID_EX_bubble,
  output logic        EX_MEM_bubble,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_load,
  input  logic [4:0]  ex_rd,
  input  logic        ex_div_start,
  input  logic        redirect_valid
);

  typedef enum logic [2:0] {
    F_IDLE   = 3'd0,
    F_REQ    = 3'd1,
    F_WAIT   = 3'd2,
    F_HOLD   = 3'd3,
    F_CANCEL = 3'd4
  } fetch_state_t;

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  fetch_state_t state_r;
  fetch_state_t state_nxt_s;
  logic [5:0]   div_cnt_r;
  logic [31:0]  buf_r;
  logic         div_busy_s;
  logic         load_use_s;
  logic         delivered_s;
  logic         held_s;

  assign div_busy_s  = ex_div_start | (div_cnt_r != 6'd0);
  assign load_use_s  = ex_load & (ex_rd != 5'd0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
  assign delivered_s = ((state_r == F_WAIT) & inst_data_ok) | (state_r == F_HOLD);
  assign held_s      = ID_stall | EX_stall;

  // Fetch state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= F_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Divide occupancy counter; a start while already busy is ignored
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_r <= 6'd0;
    end else if (ex_div_start && (div_cnt_r == 6'd0)) begin
      div_cnt_r <= DIV_LOAD;
    end else if (div_cnt_r != 6'd0) begin
      div_cnt_r <= div_cnt_r - 6'd1;
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  // Capture the returned word when decode cannot accept it this cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_r <= 32'd0;
    end else if ((state_r == F_WAIT) && inst_data_ok && !redirect_valid && held_s) begin
      buf_r <= inst_rdata;
    end else begin
      buf_r <= buf_r;
    end
  end

  // Fetch next-state and bus request
  always_comb begin
    state_nxt_s = state_r;
    inst_req    = 1'b0;
    case (state_r)
      F_IDLE: begin
        state_nxt_s = F_REQ;
      end
      F_REQ: begin
        inst_req = 1'b1;
        if (inst_addr_ok) begin
          state_nxt_s = redirect_valid ? F_CANCEL : F_WAIT;
        end else begin
          state_nxt_s = F_REQ;
        end
      end
      F_WAIT: begin
        if (redirect_valid) begin
          state_nxt_s = inst_data_ok ? F_REQ : F_CANCEL;
        end else if (inst_data_ok) begin
          state_nxt_s = held_s ? F_HOLD : F_REQ;
        end else begin
          state_nxt_s = F_WAIT;
        end
      end
      F_HOLD: begin
        if (redirect_valid || !held_s) begin
          state_nxt_s = F_REQ;
        end else begin
          state_nxt_s = F_HOLD;
        end
      end
      F_CANCEL: begin
        // The in-flight word belongs to the squashed path and is discarded
        if (inst_data_ok) begin
          state_nxt_s = F_REQ;
        end else begin
          state_nxt_s = F_CANCEL;
        end
      end
      default: begin
        state_nxt_s = F_IDLE;
      end
    endcase
  end

  // Instruction presented to IF/ID
  always_comb begin
    fetch_inst = 32'd0;
    if (state_r == F_HOLD) begin
      fetch_inst = buf_r;
    end else if (delivered_s) begin
      fetch_inst = inst_rdata;
    end else begin
      fetch_inst = 32'd0;
    end
  end

  // Fixed-priority hazard resolution: redirect > divide > load-use > fetch not ready
  always_comb begin
    IF_stall      = 1'b0;
    ID_stall      = 1'b0;
    EX_stall      = 1'b0;
    ID_EX_bubble  = 1'b0;
    EX_MEM_bubble = 1'b0;
    pc_we         = 1'b1;
    pc_redirect   = 1'b0;
    if (redirect_valid) begin
      IF_stall     = 1'b1;
      ID_EX_bubble = 1'b1;
      pc_redirect  = 1'b1;
    end else if (div_busy_s) begin
      IF_stall      = 1'b1;
      ID_stall      = 1'b1;
      EX_stall      = 1'b1;
      EX_MEM_bubble = 1'b1;
      pc_we         = 1'b0;
    end else if (load_use_s) begin
      IF_stall     = 1'b1;
      ID_stall     = 1'b1;
      ID_EX_bubble = 1'b1;
      pc_we        = 1'b0;
    end else if (!delivered_s) begin
      IF_stall = 1'b1;
      pc_we    = 1'b0;
    end else begin
      pc_we = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: the driver queues hand-computed expectations per cycle,
// an independent monitor compares them mid-cycle against the DUT outputs.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] fetch_inst;
  logic        pc_we;
  logic        pc_redirect;
  logic        IF_stall;
  logic        ID_stall;
  logic        EX_stall;
  logic        ID_EX_bubble;
  logic        EX_MEM_bubble;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_load;
  logic [4:0]  ex_rd;
  logic        ex_div_start;
  logic        redirect_valid;

  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] fi;
    int          step;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // input flags {addr_ok, data_ok, ex_load, ex_div_start, redirect_valid}
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] AO = 5'b10000;
  localparam logic [4:0] DO = 5'b01000;
  localparam logic [4:0] LD = 5'b00100;
  localparam logic [4:0] DV = 5'b00010;
  localparam logic [4:0] RD = 5'b00001;

  // expected {inst_req, pc_we, pc_redirect, IF_stall, ID_stall, EX_stall, ID_EX_bubble, EX_MEM_bubble}
  localparam logic [7:0] C_IDL  = 8'b0001_0000;
  localparam logic [7:0] C_REQ  = 8'b1001_0000;
  localparam logic [7:0] C_DLV  = 8'b0100_0000;
  localparam logic [7:0] C_LU   = 8'b0001_1010;
  localparam logic [7:0] C_LUQ  = 8'b1001_1010;
  localparam logic [7:0] C_DIV  = 8'b0001_1101;
  localparam logic [7:0] C_DIVQ = 8'b1001_1101;
  localparam logic [7:0] C_RDR  = 8'b0111_0010;
  localparam logic [7:0] C_RDRQ = 8'b1111_0010;

  pipe_hazard_ctrl #(.DIV_CYCLES(4)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req       (inst_req),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .fetch_inst     (fetch_inst),
    .pc_we          (pc_we),
    .pc_redirect    (pc_redirect),
    .IF_stall       (IF_stall),
    .ID_stall       (ID_stall),
    .EX_stall       (EX_stall),
    .ID_EX_bubble   (ID_EX_bubble),
    .EX_MEM_bubble  (EX_MEM_bubble),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .ex_load        (ex_load),
    .ex_rd          (ex_rd),
    .ex_div_start   (ex_div_start),
    .redirect_valid (redirect_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic [4:0] f, input logic [31:0] rdata,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [7:0] ctl, input logic [31:0] fi);
    exp_t e;
    @(posedge clk);
    #1;
    resetn         = rn;
    inst_addr_ok   = f[4];
    inst_data_ok   = f[3];
    ex_load        = f[2];
    ex_div_start   = f[1];
    redirect_valid = f[0];
    inst_rdata     = rdata;
    id_rs          = rs;
    id_rt          = rt;
    ex_rd          = rd;
    step_no++;
    e.ctl  = ctl;
    e.fi   = fi;
    e.step = step_no;
    exp_q.push_back(e);
  endtask

  // Monitor: compare queued expectations mid-cycle
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {inst_req, pc_we, pc_redirect, IF_stall, ID_stall, EX_stall, ID_EX_bubble, EX_MEM_bubble};
        checks++;
        if (act !== e.ctl) begin
          errors++;
          $display("FAIL ctl step %0d: got %b expected %b", e.step, act, e.ctl);
        end
        checks++;
        if (fetch_inst !== e.fi) begin
          errors++;
          $display("FAIL fetch_inst step %0d: got %h expected %h", e.step, fetch_inst, e.fi);
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
    id_rs = 5'd0; id_rt = 5'd0; ex_load = 1'b0; ex_rd = 5'd0;
    ex_div_start = 1'b0; redirect_valid = 1'b0;

    // reset and first fetch
    step(1'b0, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_IDL, 32'h0);
    step(1'b0, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_IDL, 32'h0);
    step(1'b1, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_IDL, 32'h0);
    step(1'b1, AO, 32'h0, 5'd0, 5'd0, 5'd0, C_REQ, 32'h0);
    step(1'b1, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_IDL, 32'h0);
    step(1'b1, DO, 32'h24020005, 5'd0, 5'd0, 5'd0, C_DLV, 32'h24020005);
    // load-use, then rd=0 exemption, then word held in buffer
    step(1'b1, AO | LD, 32'h0, 5'd0, 5'd5, 5'd5, C_LUQ, 32'h0);
    step(1'b1, LD, 32'h0, 5'd0, 5'd0, 5'd0, C_IDL, 32'h0);
    step(1'b1, DO | LD, 32'h8C430000, 5'd3, 5'd0, 5'd3, C_LU, 32'h8C430000);
    step(1'b1, LD, 32'hDEADBEEF, 5'd3, 5'd0, 5'd3, C_LU, 32'h8C430000);
    step(1'b1, NO, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0, C_DLV, 32'h8C430000);
    step(1'b1, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_REQ, 32'h0);
    // divide occupies EX for 4 cycles; second start while busy ignored
    step(1'b1, AO | DV, 32'h0, 5'd0, 5'd0, 5'd0, C_DIVQ, 32'h0);
    step(1'b1, DO, 32'h0085001A, 5'd0, 5'd0, 5'd0, C_DIV, 32'h0085001A);
    step(1'b1, DV, 32'h0, 5'd0, 5'd0, 5'd0, C_DIV, 32'h0085001A);
    step(1'b1, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_DIV, 32'h0085001A);
    step(1'b1, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_DLV, 32'h0085001A);
    // redirect in F_WAIT cancels the outstanding fetch
    step(1'b1, AO, 32'h0, 5'd0, 5'd0, 5'd0, C_REQ, 32'h0);
    step(1'b1, RD, 32'h0, 5'd0, 5'd0, 5'd0, C_RDR, 32'h0);
    step(1'b1, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_IDL, 32'h0);
    step(1'b1, DO, 32'h11111111, 5'd0, 5'd0, 5'd0, C_IDL, 32'h0);
    // redirect during divide: counter keeps running, EX_stall drops that cycle
    step(1'b1, DV, 32'h0, 5'd0, 5'd0, 5'd0, C_DIVQ, 32'h0);
    step(1'b1, AO | RD, 32'h0, 5'd0, 5'd0, 5'd0, C_RDRQ, 32'h0);
    step(1'b1, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_DIV, 32'h0);
    step(1'b1, DO, 32'h33333333, 5'd0, 5'd0, 5'd0, C_DIV, 32'h0);
    step(1'b1, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_REQ, 32'h0);
    // redirect together with data_ok in F_WAIT
    step(1'b1, AO, 32'h0, 5'd0, 5'd0, 5'd0, C_REQ, 32'h0);
    step(1'b1, DO | RD, 32'h22222222, 5'd0, 5'd0, 5'd0, C_RDR, 32'h22222222);
    // reset dropped mid-fetch
    step(1'b1, AO, 32'h0, 5'd0, 5'd0, 5'd0, C_REQ, 32'h0);
    step(1'b0, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_IDL, 32'h0);
    step(1'b1, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_IDL, 32'h0);
    step(1'b1, NO, 32'h0, 5'd0, 5'd0, 5'd0, C_REQ, 32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
